// File: rtl/mips_int_ctrl.sv
// -----------------------------------------------------------------------------
// mips_int_ctrl
//   Interrupt controller feeding the mips core's interrupter input.
//   Each source is synchronised and edge-detected in its own lane, and its
//   rising edges are latched into a pending bit. The masked pending set goes to
//   a lowest-index priority pick. A small FSM (IDLE -> REQ -> SERVICE) presents
//   one request at a time and holds the cause until the core acks. It then
//   tracks the handler until eret.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   irq_src      raw request lines (async to clk)
//   int_mask     per-source enable, gates selection only
//   int_ack      core took the interrupt (1-cycle pulse)
//   eret         core returned from handler (1-cycle pulse)
//   interrupter  registered request to core
//   int_cause    registered index of requested / in-service source
//   int_pending  pending register (debug readout)
//   int_busy     high while a handler is in service
// -----------------------------------------------------------------------------

// Per-source lane: 2-flop synchroniser, one delay flop for edge detect, and
// the sticky pending bit. A set in the same cycle as a clear wins.
module mips_int_ctrl_lane (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pending
);
    logic s1_q, s2_q, s3_q, pending_q;
    logic s1_d, s2_d, s3_d, pending_d;

    always_comb begin
        s1_d      = irq;
        s2_d      = s1_q;
        s3_d      = s2_q;
        pending_d = (pending_q & ~clr) | (s2_q & ~s3_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

module mips_int_ctrl #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic [N_SRC-1:0]   int_mask,
    input  logic               int_ack,
    input  logic               eret,
    output logic               interrupter,
    output logic [CAUSE_W-1:0] int_cause,
    output logic [N_SRC-1:0]   int_pending,
    output logic               int_busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               interrupter_q, interrupter_d;
    logic               int_busy_q, int_busy_d;
    logic [CAUSE_W-1:0] int_cause_q, int_cause_d;

    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   pend_clr;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   cause_oh;
    logic [CAUSE_W-1:0] winner;

    mips_int_ctrl_lane u_lane [N_SRC-1:0] (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq_src),
        .clr     (pend_clr),
        .pending (pending)
    );

    always_comb begin
        eligible = pending & int_mask;

        // Walk downward so the lowest set index is the last one written.
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CAUSE_W'(i);
        end

        // One-hot of the latched cause. Decoding avoids indexing past N_SRC
        // when CAUSE_W covers more codes than there are sources.
        cause_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (int_cause_q == CAUSE_W'(i)) cause_oh[i] = 1'b1;
        end

        state_d       = state_q;
        interrupter_d = interrupter_q;
        int_busy_d    = int_busy_q;
        int_cause_d   = int_cause_q;
        pend_clr      = '0;

        case (state_q)
            ST_IDLE: begin
                if (eligible != '0) begin
                    state_d       = ST_REQ;
                    int_cause_d   = winner;
                    interrupter_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Cause stays frozen here. Ack outranks a same-cycle eret.
                if (int_ack) begin
                    state_d       = ST_SVC;
                    interrupter_d = 1'b0;
                    int_busy_d    = 1'b1;
                    pend_clr      = cause_oh;
                end else if ((eligible & cause_oh) == '0) begin
                    // Source masked off before the core took it: withdraw.
                    state_d       = ST_IDLE;
                    interrupter_d = 1'b0;
                end
            end
            ST_SVC: begin
                if (eret) begin
                    state_d    = ST_IDLE;
                    int_busy_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                interrupter_d = 1'b0;
                int_busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            interrupter_q <= 1'b0;
            int_busy_q    <= 1'b0;
            int_cause_q   <= '0;
        end else begin
            state_q       <= state_d;
            interrupter_q <= interrupter_d;
            int_busy_q    <= int_busy_d;
            int_cause_q   <= int_cause_d;
        end
    end

    assign interrupter = interrupter_q;
    assign int_cause   = int_cause_q;
    assign int_pending = pending;
    assign int_busy    = int_busy_q;
endmodule
